// File: rtl/operand_resolve_buffer.sv
// rtl/operand_resolve_buffer.sv - per-slot operand resolver and holding register with CDB snoop
// Optional accept-cycle CDB bypass enabled by defining OPRES_CDB_BYPASS_EN.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

module operand_resolve_buffer #(
    parameter int NUM_SRC   = 2,
    parameter int XLEN      = 32,
    parameter int ROB_IDX_W = `ROB_ENTRY_WIDTH,
    parameter int NUM_CDB   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [XLEN-1:0]                in_pc,
    input  logic [XLEN-1:0]                in_imm,
    input  logic [2*NUM_SRC-1:0]           in_sel,
    input  logic [NUM_SRC-1:0]             rat_valid,
    input  logic [XLEN*NUM_SRC-1:0]        rat_value,
    input  logic [NUM_SRC-1:0]             rob_ready,
    input  logic [ROB_IDX_W*NUM_SRC-1:0]   rob_index,
    input  logic [XLEN*NUM_SRC-1:0]        rob_value,
    input  logic [NUM_CDB-1:0]             cdb_valid,
    input  logic [ROB_IDX_W*NUM_CDB-1:0]   cdb_tag,
    input  logic [XLEN*NUM_CDB-1:0]        cdb_value,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_SRC-1:0]             out_src_rdy,
    output logic [XLEN*NUM_SRC-1:0]        out_src_value,
    output logic [ROB_IDX_W*NUM_SRC-1:0]   out_src_tag
);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_e;

    state_e                              state_q, state_d;
    logic [NUM_SRC-1:0]                  rdy_q, rdy_d;
    logic [NUM_SRC-1:0][XLEN-1:0]        val_q, val_d;
    logic [NUM_SRC-1:0][ROB_IDX_W-1:0]   tag_q, tag_d;

    logic                                accept;
    logic [NUM_SRC-1:0]                  res_rdy;
    logic [NUM_SRC-1:0][XLEN-1:0]        res_val;
    logic [NUM_SRC-1:0][ROB_IDX_W-1:0]   res_tag;
    logic [NUM_SRC-1:0]                  snp_hit;
    logic [NUM_SRC-1:0][XLEN-1:0]        snp_val;

    assign in_ready = (state_q == EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            res_rdy[s] = 1'b1;
            res_val[s] = '0;
            res_tag[s] = '0;
            case (in_sel[2*s +: 2])
                2'd0:    res_val[s] = '0;
                2'd1:    res_val[s] = in_pc;
                2'd3:    res_val[s] = in_imm;
                default: begin
                    if (rat_valid[s]) begin
                        res_val[s] = rat_value[XLEN*s +: XLEN];
                    end else if (rob_ready[s]) begin
                        res_val[s] = rob_value[XLEN*s +: XLEN];
                    end else begin
                        res_rdy[s] = 1'b0;
                        res_tag[s] = rob_index[ROB_IDX_W*s +: ROB_IDX_W];
`ifdef OPRES_CDB_BYPASS_EN
                        // Descending scan so the lowest matching port is the last writer.
                        for (int p = NUM_CDB - 1; p >= 0; p--) begin
                            if (cdb_valid[p] &&
                                cdb_tag[ROB_IDX_W*p +: ROB_IDX_W] == rob_index[ROB_IDX_W*s +: ROB_IDX_W]) begin
                                res_rdy[s] = 1'b1;
                                res_val[s] = cdb_value[XLEN*p +: XLEN];
                                res_tag[s] = '0;
                            end
                        end
`endif
                    end
                end
            endcase
        end
    end

    // Qualified by !rdy only: tag 0 is a real ROB tag.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            snp_hit[s] = 1'b0;
            snp_val[s] = '0;
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (!rdy_q[s] && cdb_valid[p] &&
                    cdb_tag[ROB_IDX_W*p +: ROB_IDX_W] == tag_q[s]) begin
                    snp_hit[s] = 1'b1;
                    snp_val[s] = cdb_value[XLEN*p +: XLEN];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        val_d   = val_q;
        tag_d   = tag_q;
        if (flush) begin
            state_d = EMPTY;
            rdy_d   = '0;
            val_d   = '0;
            tag_d   = '0;
        end else if (accept) begin
            state_d = HOLD;
            rdy_d   = res_rdy;
            val_d   = res_val;
            tag_d   = res_tag;
        end else if (state_q == HOLD && out_ready) begin
            state_d = EMPTY;
            rdy_d   = '0;
            val_d   = '0;
            tag_d   = '0;
        end else if (state_q == HOLD) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (snp_hit[s]) begin
                    rdy_d[s] = 1'b1;
                    val_d[s] = snp_val[s];
                    tag_d[s] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rdy_q   <= '0;
            val_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            val_q   <= val_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid     = (state_q == HOLD);
    assign out_src_rdy   = rdy_q;
    assign out_src_value = val_q;
    assign out_src_tag   = tag_q;

endmodule

// File: tb/tb_operand_resolve_buffer.sv
// tb/tb_operand_resolve_buffer.sv - randomized self-checking bench for operand_resolve_buffer
module tb_operand_resolve_buffer;

    localparam int NS = 2;
    localparam int XL = 32;
    localparam int TW = 6;
    localparam int NC = 2;

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [XL-1:0]     in_pc, in_imm;
    logic [2*NS-1:0]   in_sel;
    logic [NS-1:0]     rat_valid, rob_ready, out_src_rdy;
    logic [XL*NS-1:0]  rat_value, rob_value, out_src_value;
    logic [TW*NS-1:0]  rob_index, out_src_tag;
    logic [NC-1:0]     cdb_valid;
    logic [TW*NC-1:0]  cdb_tag;
    logic [XL*NC-1:0]  cdb_value;

    operand_resolve_buffer #(.NUM_SRC(NS), .XLEN(XL), .ROB_IDX_W(TW), .NUM_CDB(NC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_sel(in_sel), .rat_valid(rat_valid),
        .rat_value(rat_value), .rob_ready(rob_ready), .rob_index(rob_index),
        .rob_value(rob_value), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .out_valid(out_valid), .out_ready(out_ready),
        .out_src_rdy(out_src_rdy), .out_src_value(out_src_value), .out_src_tag(out_src_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic          m_valid;
    logic          m_rdy [NS];
    logic [XL-1:0] m_val [NS];
    logic [TW-1:0] m_tag [NS];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        for (int s = 0; s < NS; s++) begin
            m_rdy[s] = 1'b0;
            m_val[s] = '0;
            m_tag[s] = '0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n || flush) begin
            model_clear();
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1'b1;
            for (int s = 0; s < NS; s++) begin
                int sel;
                sel = int'(in_sel[2*s +: 2]);
                m_rdy[s] = 1'b1;
                m_tag[s] = '0;
                if (sel == 0)                m_val[s] = '0;
                else if (sel == 1)           m_val[s] = in_pc;
                else if (sel == 3)           m_val[s] = in_imm;
                else if (rat_valid[s])       m_val[s] = rat_value[XL*s +: XL];
                else if (rob_ready[s])       m_val[s] = rob_value[XL*s +: XL];
                else begin
                    m_rdy[s] = 1'b0;
                    m_val[s] = '0;
                    m_tag[s] = rob_index[TW*s +: TW];
`ifdef OPRES_CDB_BYPASS_EN
                    for (int p = 0; p < NC; p++) begin
                        if (cdb_valid[p] && cdb_tag[TW*p +: TW] == m_tag[s]) begin
                            m_rdy[s] = 1'b1;
                            m_val[s] = cdb_value[XL*p +: XL];
                            m_tag[s] = '0;
                            break;
                        end
                    end
`endif
                end
            end
        end else if (m_valid && out_ready) begin
            model_clear();
        end else if (m_valid) begin
            for (int s = 0; s < NS; s++) begin
                if (!m_rdy[s]) begin
                    for (int p = 0; p < NC; p++) begin
                        if (cdb_valid[p] && cdb_tag[TW*p +: TW] == m_tag[s]) begin
                            m_rdy[s] = 1'b1;
                            m_val[s] = cdb_value[XL*p +: XL];
                            m_tag[s] = '0;
                            break;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        logic [XL*NS-1:0] ev;
        logic [TW*NS-1:0] et;
        logic [NS-1:0]    er;
        #1 chk("in_ready", 128'(in_ready), 128'(!m_valid || out_ready));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int s = 0; s < NS; s++) begin
            ev[XL*s +: XL] = m_val[s];
            et[TW*s +: TW] = m_tag[s];
            er[s]          = m_rdy[s];
        end
        chk("out_valid", 128'(out_valid), 128'(m_valid));
        chk("out_src_rdy", 128'(out_src_rdy), 128'(er));
        chk("out_src_value", 128'(out_src_value), 128'(ev));
        chk("out_src_tag", 128'(out_src_tag), 128'(et));
    endtask

    task automatic idle();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_imm = '0; in_sel = '0; rat_valid = '0; rat_value = '0;
        rob_ready = '0; rob_index = '0; rob_value = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    endtask

    initial begin
        idle();
        model_clear();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cycle();
        chk("reset_valid", 128'(out_valid), 128'(0));

        // Immediate / PC sources
        idle(); in_valid = 1'b1; in_sel = {2'd3, 2'd1}; in_pc = 32'h100; in_imm = 32'h20;
        cycle();
        chk("t1_rdy", 128'(out_src_rdy), 128'(2'b11));
        chk("t1_value", 128'(out_src_value), 128'({32'h20, 32'h100}));
        idle(); out_ready = 1'b1;
        cycle();

        // Pending operand woken by CDB
        idle(); in_valid = 1'b1; in_sel = {2'd0, 2'd2}; rob_index = {6'd0, 6'd5};
        cycle();
        chk("t2_pend_rdy", 128'(out_src_rdy[0]), 128'(0));
        chk("t2_pend_tag", 128'(out_src_tag[TW-1:0]), 128'(5));
        idle(); cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd5}; cdb_value = {32'h0, 32'hDEAD};
        cycle();
        chk("t2_wake_rdy", 128'(out_src_rdy[0]), 128'(1));
        chk("t2_wake_val", 128'(out_src_value[XL-1:0]), 128'(32'hDEAD));
        chk("t2_wake_tag", 128'(out_src_tag[TW-1:0]), 128'(0));

        // Both CDB ports match: port 0 wins; tag 0 is legal
        idle(); in_valid = 1'b1; out_ready = 1'b1; in_sel = {2'd2, 2'd2}; rob_index = {6'd0, 6'd0};
        cycle();
        idle(); cdb_valid = 2'b11; cdb_tag = {6'd0, 6'd0}; cdb_value = {32'h222, 32'h111};
        cycle();
        chk("cdb_prio", 128'(out_src_value), 128'({32'h111, 32'h111}));

        // Back-to-back throughput
        for (int i = 0; i < 4; i++) begin
            idle(); in_valid = 1'b1; out_ready = 1'b1; in_sel = {2'd1, 2'd1}; in_pc = 32'(i + 1);
            #1 chk("b2b_in_ready", 128'(in_ready), 128'(1));
            cycle();
            chk("b2b_value", 128'(out_src_value[XL-1:0]), 128'(i + 1));
        end

        // Flush while holding
        idle(); in_valid = 1'b1; in_sel = {2'd1, 2'd1}; in_pc = 32'h44; out_ready = 1'b1;
        cycle();
        idle(); flush = 1'b1; in_valid = 1'b1; in_sel = {2'd1, 2'd1}; in_pc = 32'h99; out_ready = 1'b1;
        cycle();
        chk("flush_valid", 128'(out_valid), 128'(0));
        idle();
        cycle();
        chk("flush_no_emit", 128'(out_valid), 128'(0));

        // Accept-cycle CDB race
        idle(); in_valid = 1'b1; in_sel = {2'd0, 2'd2}; rob_index = {6'd0, 6'd7};
        cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd7}; cdb_value = {32'h0, 32'h55};
        cycle();
`ifdef OPRES_CDB_BYPASS_EN
        chk("bypass_rdy", 128'(out_src_rdy[0]), 128'(1));
        chk("bypass_val", 128'(out_src_value[XL-1:0]), 128'(32'h55));
`else
        chk("nobypass_rdy", 128'(out_src_rdy[0]), 128'(0));
        chk("nobypass_tag", 128'(out_src_tag[TW-1:0]), 128'(7));
`endif

        // Reset mid-hold with a pending source
        idle(); in_valid = 1'b1; out_ready = 1'b1; in_sel = {2'd3, 2'd2}; rob_index = {6'd0, 6'd3}; in_imm = 32'h77;
        cycle();
        idle(); rst_n = 1'b0; in_valid = 1'b1; in_sel = {2'd1, 2'd1}; in_pc = 32'h12;
        cycle();
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_all", 128'({out_src_rdy, out_src_value, out_src_tag}), 128'(0));

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 2) == 0);
            in_sel    = 4'($urandom);
            rat_valid = 2'($urandom) & 2'($urandom);
            rob_ready = 2'($urandom) & 2'($urandom);
            in_pc     = $urandom;
            in_imm    = $urandom;
            rat_value = {$urandom, $urandom};
            rob_value = {$urandom, $urandom};
            cdb_valid = 2'($urandom);
            cdb_value = {$urandom, $urandom};
            for (int s = 0; s < NS; s++) rob_index[TW*s +: TW] = TW'($urandom_range(0, 3));
            for (int p = 0; p < NC; p++) cdb_tag[TW*p +: TW] = TW'($urandom_range(0, 3));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
